// File: rtl/uart_io_arbiter.sv
// uart_io_arbiter: shares one uart_io byte port among NREQ requesters with
// round-robin selection and an optional per-requester lock for multi-byte runs.
module uart_io_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdata,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              uart_ren,
    output logic              uart_wen,
    output logic [7:0]        uart_wdata,
    input  logic [7:0]        uart_rdata,
    input  logic              uart_rbusy,
    input  logic              uart_rdone,
    input  logic              uart_wbusy,
    input  logic              uart_wdone
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT_R = 3'd2,
        WAIT_W = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    logic [IW-1:0]   g;
    logic [IW-1:0]   rr_ptr;
    logic            we;
    logic            lock_active;
    logic [NREQ-1:0] mask;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot = NREQ'(1) << i;
    endfunction

    // Index k positions after base, wrapping modulo NREQ.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned k);
        rr_idx = IW'((32'(base) + k) % NREQ);
    endfunction

    // Per-requester write byte lanes.
    logic [7:0] wdata_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign wdata_arr[i] = req_wdata[8*i +: 8];
    end

    logic            lock_hold_c;
    logic [NREQ-1:0] eligible_c;
    logic            win_c;
    logic [IW-1:0]   win_idx_c;

    // Round-robin pick from rr_ptr; a held lock restricts eligibility to the owner.
    always_comb begin
        lock_hold_c = lock_active && req_lock[g];
        eligible_c  = req & ~mask;
        if (lock_hold_c) begin
            eligible_c = eligible_c & onehot(g);
        end
        win_c     = 1'b0;
        win_idx_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!win_c && eligible_c[rr_idx(rr_ptr, k)]) begin
                win_c     = 1'b1;
                win_idx_c = rr_idx(rr_ptr, k);
            end
        end
    end

    // Arbiter FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            g           <= '0;
            rr_ptr      <= '0;
            we          <= 1'b0;
            lock_active <= 1'b0;
            mask        <= '0;
            ack         <= '0;
            rdata       <= 8'h00;
            grant       <= '0;
            busy        <= 1'b0;
            uart_ren    <= 1'b0;
            uart_wen    <= 1'b0;
            uart_wdata  <= 8'h00;
        end else begin
            ack      <= '0;
            uart_ren <= 1'b0;
            uart_wen <= 1'b0;
            case (state)
                IDLE: begin
                    mask        <= '0;
                    lock_active <= lock_hold_c;
                    if (win_c) begin
                        g          <= win_idx_c;
                        we         <= req_we[win_idx_c];
                        uart_wdata <= wdata_arr[win_idx_c];
                        grant      <= onehot(win_idx_c);
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end else if (!lock_hold_c) begin
                        grant <= '0;
                    end
                end
                ISSUE: begin
                    if (!(uart_rbusy || uart_wbusy)) begin
                        if (we) begin
                            uart_wen <= 1'b1;
                            state    <= WAIT_W;
                        end else begin
                            uart_ren <= 1'b1;
                            state    <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (uart_rdone) begin
                        rdata <= uart_rdata;
                        ack   <= onehot(g);
                        state <= DONE;
                    end
                end
                WAIT_W: begin
                    if (uart_wdone) begin
                        ack   <= onehot(g);
                        state <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr      <= rr_idx(g, 1);
                    mask        <= onehot(g);
                    lock_active <= req_lock[g];
                    if (!req_lock[g]) begin
                        grant <= '0;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_arbiter.sv
// tb_uart_io_arbiter: directed scenarios plus randomized multi-requester traffic
// checked against a transaction-level round-robin reference model.
module tb_uart_io_arbiter;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, req_we, req_lock;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]  ack, grant;
    logic [7:0]    rdata;
    logic          busy, uart_ren, uart_wen;
    logic [7:0]    uart_wdata, uart_rdata;
    logic          uart_rbusy, uart_rdone, uart_wbusy, uart_wdone;

    int n_tests = 0;
    int n_fail  = 0;

    // uart_io responder state and bench logs
    bit          resp_en;
    int          resp_max;
    bit          pend, pend_we;
    int          cnt;
    logic [7:0]  rx_q[$];
    int          ack_idx_q[$];
    logic [7:0]  ack_rd_q[$];
    logic        iss_we_q[$];
    logic [7:0]  iss_wd_q[$];

    uart_io_arbiter #(.NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_we(req_we), .req_lock(req_lock), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
        .uart_ren(uart_ren), .uart_wen(uart_wen), .uart_wdata(uart_wdata),
        .uart_rdata(uart_rdata), .uart_rbusy(uart_rbusy), .uart_rdone(uart_rdone),
        .uart_wbusy(uart_wbusy), .uart_wdone(uart_wdone)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample 1ns after the edge, log events, drive the uart_io model.
    task automatic tick();
        @(posedge clk);
        #1;
        uart_rdone = 1'b0;
        uart_wdone = 1'b0;
        if (uart_wen) begin iss_we_q.push_back(1'b1); iss_wd_q.push_back(uart_wdata); end
        if (uart_ren) begin iss_we_q.push_back(1'b0); iss_wd_q.push_back(8'h00); end
        if (|ack) begin
            for (int i = 0; i < N; i++) if (ack[i]) ack_idx_q.push_back(i);
            ack_rd_q.push_back(rdata);
        end
        if (resp_en) begin
            if (uart_wen || uart_ren) begin
                pend    = 1'b1;
                pend_we = uart_wen;
                cnt     = int'($urandom_range(0, resp_max));
            end
            if (pend) begin
                if (cnt == 0) begin
                    pend = 1'b0;
                    if (pend_we) uart_wdone = 1'b1;
                    else begin
                        uart_rdone = 1'b1;
                        uart_rdata = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
                    end
                end else cnt--;
            end
        end
    endtask

    task automatic clear_logs();
        ack_idx_q.delete(); ack_rd_q.delete(); iss_we_q.delete(); iss_wd_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_we = '0; req_lock = '0; req_wdata = '0;
        uart_rdata = 8'h00; uart_rbusy = 1'b0; uart_wbusy = 1'b0;
        uart_rdone = 1'b0; uart_wdone = 1'b0;
        resp_en = 1'b0; resp_max = 0; pend = 1'b0; pend_we = 1'b0; cnt = 0;
        rx_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; req_we = 2'b11; req_lock = 2'b11; req_wdata = 16'hFFFF;
        uart_rdata = 8'h00; uart_rbusy = 1'b0; uart_wbusy = 1'b0;
        uart_rdone = 1'b0; uart_wdone = 1'b0; resp_en = 1'b0;
        tick(); tick();
        n_tests++;
        if ({ack, grant} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ack_grant: got ack=%b grant=%b, want 00 00", ack, grant);
        end
        n_tests++;
        if ({busy, uart_ren, uart_wen} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got busy/ren/wen=%b, want 000", {busy, uart_ren, uart_wen});
        end
        n_tests++;
        if ({rdata, uart_wdata} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got rdata=%h wdata=%h, want 00 00", rdata, uart_wdata);
        end
        do_reset();
    endtask

    task automatic test_write_single();
        bit bad;
        do_reset();
        req_we[0] = 1'b1; req_wdata[7:0] = 8'h41; req[0] = 1'b1;
        tick();
        n_tests++;
        if (grant !== 2'b01 || busy !== 1'b1 || uart_wen !== 1'b0) begin
            n_fail++; $display("FAIL wr_grant: got grant=%b busy=%b wen=%b, want 01 1 0", grant, busy, uart_wen);
        end
        tick();
        n_tests++;
        if (uart_wen !== 1'b1 || uart_wdata !== 8'h41) begin
            n_fail++; $display("FAIL wr_wen: got wen=%b wdata=%h, want 1 41", uart_wen, uart_wdata);
        end
        bad = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (uart_wen !== 1'b0 || uart_wdata !== 8'h41 || ack !== 2'b00) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL wr_hold: got wen=%b wdata=%h ack=%b, want 0 41 00", uart_wen, uart_wdata, ack);
        end
        uart_wdone = 1'b1;
        tick();
        n_tests++;
        if (ack !== 2'b01) begin
            n_fail++; $display("FAIL wr_ack: got ack=%b, want 01", ack);
        end
        req[0] = 1'b0;
        tick();
        n_tests++;
        if (ack !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_after: got ack=%b grant=%b busy=%b, want 00 00 0", ack, grant, busy);
        end
    endtask

    task automatic test_read_pair();
        do_reset();
        resp_en = 1'b1; resp_max = 2;
        rx_q.push_back(8'h12); rx_q.push_back(8'h34);
        req_we = 2'b00; req = 2'b11;
        for (int t = 0; t < 60 && ack_idx_q.size() < 2; t++) begin
            tick();
            for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
        end
        n_tests++;
        if (ack_idx_q.size() != 2) begin
            n_fail++; $display("FAIL rd_pair_count: got %0d acks, want 2", ack_idx_q.size());
        end else begin
            n_tests++;
            if (ack_idx_q[0] != 0 || ack_idx_q[1] != 1) begin
                n_fail++; $display("FAIL rd_pair_order: got %0d,%0d, want 0,1", ack_idx_q[0], ack_idx_q[1]);
            end
            n_tests++;
            if (ack_rd_q[0] !== 8'h12 || ack_rd_q[1] !== 8'h34) begin
                n_fail++; $display("FAIL rd_pair_data: got %h,%h, want 12,34", ack_rd_q[0], ack_rd_q[1]);
            end
        end
        tick(); tick(); tick();
        n_tests++;
        if (rdata !== 8'h34) begin
            n_fail++; $display("FAIL rd_hold: got rdata=%h, want 34", rdata);
        end
    endtask

    task automatic test_lock();
        logic [7:0] lw[4];
        int         exp_idx[5];
        logic [7:0] exp_wd[5];
        int         n1;
        bit         chk1, chk3, bad;
        lw[0] = 8'hA0; lw[1] = 8'hA1; lw[2] = 8'hA2; lw[3] = 8'hA3;
        exp_idx[0] = 1; exp_idx[1] = 1; exp_idx[2] = 1; exp_idx[3] = 0; exp_idx[4] = 1;
        exp_wd[0] = 8'hA0; exp_wd[1] = 8'hA1; exp_wd[2] = 8'hA2; exp_wd[3] = 8'h55; exp_wd[4] = 8'hA3;
        do_reset();
        resp_en = 1'b1; resp_max = 1;
        req_we = 2'b11; req_lock = 2'b10; req_wdata[15:8] = lw[0]; req[1] = 1'b1;
        tick();
        n_tests++;
        if (grant !== 2'b10) begin
            n_fail++; $display("FAIL lock_first: got grant=%b, want 10", grant);
        end
        req_wdata[7:0] = 8'h55; req[0] = 1'b1;
        n1 = 0; chk1 = 1'b0; chk3 = 1'b0;
        for (int t = 0; t < 300 && ack_idx_q.size() < 5; t++) begin
            tick();
            if (chk1) begin
                chk1 = 1'b0; n_tests++;
                if (grant !== 2'b10 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL lock_grant_kept: got grant=%b busy=%b, want 10 0", grant, busy);
                end
            end
            if (chk3) begin
                chk3 = 1'b0; n_tests++;
                if (grant !== 2'b00) begin
                    n_fail++; $display("FAIL lock_release: got grant=%b, want 00", grant);
                end
            end
            if (ack[1]) begin
                n1++;
                if (n1 < 4) req_wdata[15:8] = lw[n1];
                if (n1 == 1) chk1 = 1'b1;
                if (n1 == 3) begin req_lock[1] = 1'b0; chk3 = 1'b1; end
                if (n1 == 4) req[1] = 1'b0;
            end
            if (ack[0]) req[0] = 1'b0;
        end
        n_tests++;
        bad = (ack_idx_q.size() != 5) || (iss_wd_q.size() != 5);
        for (int k = 0; k < 5 && !bad; k++)
            if (ack_idx_q[k] != exp_idx[k] || iss_wd_q[k] !== exp_wd[k]) bad = 1'b1;
        if (bad) begin
            n_fail++;
            $display("FAIL lock_sequence: got %0d acks / %0d writes, want order 1,1,1,0,1 data A0,A1,A2,55,A3",
                     ack_idx_q.size(), iss_wd_q.size());
        end
    endtask

    task automatic test_rbusy_hold();
        int nren;
        do_reset();
        uart_rbusy = 1'b1; req_we[0] = 1'b0; req[0] = 1'b1;
        nren = 0;
        for (int t = 0; t < 20; t++) begin tick(); if (uart_ren) nren++; end
        n_tests++;
        if (nren != 0 || busy !== 1'b1 || grant !== 2'b01) begin
            n_fail++; $display("FAIL rbusy_hold: got ren pulses=%0d busy=%b grant=%b, want 0 1 01", nren, busy, grant);
        end
        uart_rbusy = 1'b0; nren = 0;
        for (int t = 0; t < 6; t++) begin tick(); if (uart_ren) nren++; end
        n_tests++;
        if (nren != 1) begin
            n_fail++; $display("FAIL rbusy_release: got ren pulses=%0d, want 1", nren);
        end
        uart_rdata = 8'h77; uart_rdone = 1'b1;
        tick();
        n_tests++;
        if (ack !== 2'b01 || rdata !== 8'h77) begin
            n_fail++; $display("FAIL rbusy_ack: got ack=%b rdata=%h, want 01 77", ack, rdata);
        end
        req[0] = 1'b0;
        tick();
    endtask

    task automatic test_stray();
        do_reset();
        uart_rdata = 8'h99; uart_rdone = 1'b1;
        tick(); tick();
        uart_wdone = 1'b1;
        tick(); tick();
        n_tests++;
        if (ack !== 2'b00 || busy !== 1'b0 || grant !== 2'b00 || rdata !== 8'h00) begin
            n_fail++; $display("FAIL stray_idle: got ack=%b busy=%b grant=%b rdata=%h, want 00 0 00 00", ack, busy, grant, rdata);
        end
        req_we[1] = 1'b1; req_wdata[15:8] = 8'h3C; req[1] = 1'b1;
        tick(); tick();
        n_tests++;
        if (uart_wen !== 1'b1 || uart_wdata !== 8'h3C) begin
            n_fail++; $display("FAIL stray_wen: got wen=%b wdata=%h, want 1 3C", uart_wen, uart_wdata);
        end
        uart_rdone = 1'b1;
        tick(); tick();
        n_tests++;
        if (ack !== 2'b00 || busy !== 1'b1 || grant !== 2'b10 || rdata !== 8'h00) begin
            n_fail++; $display("FAIL stray_waitw: got ack=%b busy=%b grant=%b rdata=%h, want 00 1 10 00", ack, busy, grant, rdata);
        end
        uart_wdone = 1'b1;
        tick();
        n_tests++;
        if (ack !== 2'b10) begin
            n_fail++; $display("FAIL stray_ack: got ack=%b, want 10", ack);
        end
        req[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_we[0] = 1'b0; req[0] = 1'b1;
        tick(); tick();
        n_tests++;
        if (uart_ren !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ren: got ren=%b, want 1", uart_ren);
        end
        tick();
        rst = 1'b1; req = '0;
        tick();
        n_tests++;
        if ({ack, grant, busy, uart_ren, uart_wen, rdata, uart_wdata} !== 23'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got ack=%b grant=%b busy=%b rdata=%h, want all 0", ack, grant, busy, rdata);
        end
        rst = 1'b0;
        uart_rdata = 8'hAB; uart_rdone = 1'b1;
        tick(); tick();
        n_tests++;
        if (ack !== 2'b00 || rdata !== 8'h00 || busy !== 1'b0 || grant !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_late_rdone: got ack=%b rdata=%h busy=%b grant=%b, want 00 00 0 00", ack, rdata, busy, grant);
        end
    endtask

    task automatic test_random(input int round);
        logic       tw[N][8];
        logic [7:0] td[N][8];
        int         len[N];
        int         pos[N];
        logic [7:0] rxl[16];
        int         e_idx[$];
        logic       e_we[$];
        logic [7:0] e_wd[$];
        logic [7:0] e_rd[$];
        int         ptr, sel, rk, rd_seen;
        do_reset();
        for (int i = 0; i < N; i++) begin
            len[i] = int'($urandom_range(3, 6));
            for (int j = 0; j < 8; j++) begin
                tw[i][j] = 1'($urandom_range(0, 1));
                td[i][j] = 8'($urandom);
            end
        end
        for (int k = 0; k < 16; k++) begin
            rxl[k] = 8'($urandom);
            rx_q.push_back(rxl[k]);
        end
        // Reference: every requester keeps its queue pending, so each grant goes to
        // the next non-empty queue after the previous winner, starting at index 0.
        ptr = 0; rk = 0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        for (int n = 0; n < 64; n++) begin
            sel = -1;
            for (int k = 0; k < N; k++)
                if (sel < 0 && pos[(ptr + k) % N] < len[(ptr + k) % N]) sel = (ptr + k) % N;
            if (sel < 0) break;
            e_idx.push_back(sel);
            e_we.push_back(tw[sel][pos[sel]]);
            e_wd.push_back(td[sel][pos[sel]]);
            if (!tw[sel][pos[sel]]) begin e_rd.push_back(rxl[rk]); rk++; end
            pos[sel]++;
            ptr = (sel + 1) % N;
        end
        resp_en = 1'b1; resp_max = 3;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            req_we[i] = tw[i][0];
            req_wdata[8*i +: 8] = td[i][0];
            req[i] = 1'b1;
        end
        for (int t = 0; t < 1500 && ack_idx_q.size() < e_idx.size(); t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    pos[i]++;
                    if (pos[i] < len[i]) begin
                        req_we[i] = tw[i][pos[i]];
                        req_wdata[8*i +: 8] = td[i][pos[i]];
                    end else req[i] = 1'b0;
                end
            end
        end
        n_tests++;
        if (ack_idx_q.size() != e_idx.size() || iss_we_q.size() != e_idx.size()) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d acks %0d issues, want %0d", round, ack_idx_q.size(), iss_we_q.size(), e_idx.size());
        end else begin
            rd_seen = 0;
            for (int k = 0; k < e_idx.size(); k++) begin
                n_tests++;
                if (ack_idx_q[k] != e_idx[k] || iss_we_q[k] !== e_we[k] || (e_we[k] && iss_wd_q[k] !== e_wd[k])) begin
                    n_fail++;
                    $display("FAIL rand%0d_txn%0d: got req=%0d we=%b wdata=%h, want req=%0d we=%b wdata=%h",
                             round, k, ack_idx_q[k], iss_we_q[k], iss_wd_q[k], e_idx[k], e_we[k], e_wd[k]);
                end
                if (!e_we[k]) begin
                    n_tests++;
                    if (ack_rd_q[k] !== e_rd[rd_seen]) begin
                        n_fail++;
                        $display("FAIL rand%0d_rdata%0d: got %h, want %h", round, k, ack_rd_q[k], e_rd[rd_seen]);
                    end
                    rd_seen++;
                end
            end
        end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_read_pair();
        test_lock();
        test_rbusy_hold();
        test_stray();
        test_reset_mid();
        for (int r = 0; r < 4; r++) test_random(r);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
